controller_fsm: RTL and testbench

// - Control FSM of the Genius game: drives the datapath enables/resets (R1,R2,E1..E4,SEL) and consumes its status flags.
// - Sits directly upstream of the datapath; the top level wires both together with CLOCK_50 and the board KEY/SWITCH.
// - Sequences setup, FPGA sequence playback, user entry, per-entry check, round advance and result display.

---
 rtl/controller_fsm_pkg.sv | 26 ++
 rtl/controller_fsm_key_pulse.sv | 47 ++++
 rtl/controller_fsm.sv | 86 ++++++++
 tb/tb_controller_fsm.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/controller_fsm_pkg.sv
// Genius game controller: state codes, default state width and datapath control bundle.
package controller_fsm_pkg;

   localparam int P_STATE_DEF = 3;

   typedef enum logic [2:0] {
      ST_INIT      = 3'd0,
      ST_SETUP     = 3'd1,
      ST_PLAY_FPGA = 3'd2,
      ST_PLAY_USER = 3'd3,
      ST_CHECK     = 3'd4,
      ST_NEXT      = 3'd5,
      ST_RESULT    = 3'd6
   } state_e;

   typedef struct packed {
      logic r1;
      logic r2;
      logic e1;
      logic e2;
      logic e3;
      logic e4;
      logic sel;
   } ctrl_t;

endpackage

// File: rtl/controller_fsm_key_pulse.sv
// ENTER conditioning: optional 2-flop synchronizer (CTRL_SYNC_EN), polarity normalization,
// one-cycle pulse on the inactive->active edge.
module key_pulse #(
   parameter bit p_enter_low = 1'b1
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   input  logic key_i,
   output logic pulse_o
);

   logic act, settled, prev_q, armed_q;

`ifdef CTRL_SYNC_EN
   logic [1:0] sync_q, fill_q;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_q <= {2{p_enter_low}};
         fill_q <= '0;
      end else begin
         sync_q <= {sync_q[0], key_i};
         fill_q <= {fill_q[0], 1'b1};
      end
   end

   assign act     = sync_q[1] ^ p_enter_low;
   assign settled = fill_q[1];
`else
   assign act     = key_i ^ p_enter_low;
   assign settled = 1'b1;
`endif

   // A key already held when reset releases must be seen released before it can fire.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         prev_q <= act;
         if (settled && !act) armed_q <= 1'b1;
      end
   end

   assign pulse_o = act & ~prev_q & armed_q;

endmodule

// File: rtl/controller_fsm.sv
// Genius game control FSM (Moore). Define CTRL_SYNC_EN to synchronize ENTER inside the block.
module controller_fsm
   import controller_fsm_pkg::*;
#(
   parameter bit p_enter_low = 1'b1,
   parameter int p_state     = P_STATE_DEF
) (
   input  logic               CLOCK_50,
   input  logic               RESET_N,
   input  logic               ENTER,
   input  logic               end_FPGA,
   input  logic               end_User,
   input  logic               end_time,
   input  logic               win,
   input  logic               match,
   output logic               R1,
   output logic               R2,
   output logic               E1,
   output logic               E2,
   output logic               E3,
   output logic               E4,
   output logic               SEL,
   output logic [p_state-1:0] state_o
);

   state_e state_q, state_d;
   ctrl_t  ctrl;
   logic   press;

   key_pulse #(.p_enter_low(p_enter_low)) u_key (
      .CLOCK_50(CLOCK_50),
      .RESET_N (RESET_N),
      .key_i   (ENTER),
      .pulse_o (press)
   );

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) state_q <= ST_INIT;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT:      state_d = ST_SETUP;
         ST_SETUP:     if (press) state_d = ST_PLAY_FPGA;
         ST_PLAY_FPGA: if (end_FPGA) state_d = ST_PLAY_USER;
         ST_PLAY_USER: begin
            if (end_time)   state_d = ST_RESULT;
            else if (press) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (!match || win) state_d = ST_RESULT;
            else if (end_User) state_d = ST_NEXT;
            else               state_d = ST_PLAY_USER;
         end
         ST_NEXT:      state_d = ST_PLAY_FPGA;
         ST_RESULT:    if (press) state_d = ST_INIT;
         default:      state_d = ST_INIT;
      endcase
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         ST_INIT:      begin ctrl.r1 = 1'b1; ctrl.r2 = 1'b1; end
         ST_SETUP:     ctrl.e1 = 1'b1;
         ST_PLAY_FPGA: begin ctrl.e3 = 1'b1; ctrl.r2 = 1'b1; end
         ST_PLAY_USER: ctrl.e2 = 1'b1;
         ST_CHECK:     ctrl.e4 = 1'b1;
         ST_NEXT:      begin ctrl.r2 = 1'b1; ctrl.e4 = 1'b1; end
         ST_RESULT:    ctrl.sel = 1'b1;
         default:      ctrl = '0;
      endcase
   end

   assign R1      = ctrl.r1;
   assign R2      = ctrl.r2;
   assign E1      = ctrl.e1;
   assign E2      = ctrl.e2;
   assign E3      = ctrl.e3;
   assign E4      = ctrl.e4;
   assign SEL     = ctrl.sel;
   assign state_o = p_state'(state_q);

endmodule

// File: tb/tb_controller_fsm.sv
// Scoreboard bench for controller_fsm: directed game walk plus randomized play against a rule model.
module tb_controller_fsm;
   import controller_fsm_pkg::*;

`ifdef CTRL_SYNC_EN
   localparam int D = 2;
`else
   localparam int D = 0;
`endif

   localparam logic [4:0] F_EF = 5'b10000, F_EU = 5'b01000, F_ET = 5'b00100,
                          F_W  = 5'b00010, F_M  = 5'b00001;

   logic CLOCK_50 = 1'b0;
   logic RESET_N = 1'b0, ENTER = 1'b1;
   logic end_FPGA = 1'b0, end_User = 1'b0, end_time = 1'b0, win = 1'b0, match = 1'b0;
   logic R1, R2, E1, E2, E3, E4, SEL;
   logic [2:0] state_o;

   always #5 CLOCK_50 = ~CLOCK_50;

   controller_fsm #(.p_enter_low(1'b1), .p_state(3)) dut (
      .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .ENTER(ENTER),
      .end_FPGA(end_FPGA), .end_User(end_User), .end_time(end_time),
      .win(win), .match(match),
      .R1(R1), .R2(R2), .E1(E1), .E2(E2), .E3(E3), .E4(E4), .SEL(SEL),
      .state_o(state_o)
   );

   typedef struct {
      int         st;
      logic [6:0] outs;
      string      tag;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0, n_chk = 0;

   // model: state index plus the post-reset history of the "key is pressed" level
   int m_st = 0;
   bit hist[$];

   // {R1,R2,E1,E2,E3,E4,SEL} asserted per state
   function automatic logic [6:0] outs_of(input int s);
      case (s)
         0: return 7'b1100000;
         1: return 7'b0010000;
         2: return 7'b0100100;
         3: return 7'b0001000;
         4: return 7'b0000010;
         5: return 7'b0100010;
         6: return 7'b0000001;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic int next_of(input int s, input bit pr, input logic [4:0] f);
      bit ef = f[4], eu = f[3], et = f[2], w = f[1], m = f[0];
      case (s)
         0: return 1;
         1: return pr ? 2 : 1;
         2: return ef ? 3 : 2;
         3: return et ? 6 : (pr ? 4 : 3);
         4: return (!m || w) ? 6 : (eu ? 5 : 3);
         5: return 2;
         6: return pr ? 0 : 6;
         default: return 0;
      endcase
   endfunction

   // Drive one cycle's inputs (a = key pressed), predict the state after the next edge.
   task automatic cycle(input bit a, input logic [4:0] f, input bit rst_n, input string tag);
      int k;
      bit pr;
      RESET_N  = rst_n;
      ENTER    = ~a;
      end_FPGA = f[4]; end_User = f[3]; end_time = f[2]; win = f[1]; match = f[0];
      if (!rst_n) begin
         hist.delete();
         m_st = 0;
      end else begin
         hist.push_back(a);
         k  = hist.size() - 1 - D;
         pr = (k >= 1) && hist[k] && !hist[k-1];
         m_st = next_of(m_st, pr, f);
      end
      q.push_back('{m_st, outs_of(m_st), tag});
      @(posedge CLOCK_50); #2;
   endtask

   task automatic hold(input int n, input bit a, input logic [4:0] f, input string tag);
      repeat (n) cycle(a, f, 1'b1, tag);
   endtask

   task automatic press(input logic [4:0] f, input string tag);
      cycle(1'b1, f, 1'b1, tag);
      hold(4, 1'b0, f, tag);
   endtask

   task automatic async_reset(input bit a);
      RESET_N = 1'b0;
      #1;
      n_chk++;
      if (state_o == 3'd0 && {R1, R2, E1, E2, E3, E4, SEL} == 7'b1100000) n_pass++;
      else $display("FAIL async_reset: state_o=%0d outs=%b expected state=0 outs=1100000",
                    state_o, {R1, R2, E1, E2, E3, E4, SEL});
      cycle(a, 5'b0, 1'b0, "in_reset");
      cycle(a, 5'b0, 1'b0, "in_reset");
   endtask

   // monitor: every clock the DUT presents a new Moore state; check the oldest prediction
   initial begin
      exp_t e;
      forever begin
         @(posedge CLOCK_50); #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            if (state_o == 3'(e.st) && {R1, R2, E1, E2, E3, E4, SEL} == e.outs) n_pass++;
            else $display("FAIL %s: state_o=%0d outs=%b expected state=%0d outs=%b",
                          e.tag, state_o, {R1, R2, E1, E2, E3, E4, SEL}, e.st, e.outs);
         end
      end
   end

   initial begin
      bit a;
      logic [4:0] f;
      @(posedge CLOCK_50); #2;
      cycle(1'b0, 5'b0, 1'b0, "reset");
      cycle(1'b0, 5'b0, 1'b0, "reset");
      hold(2, 1'b0, 5'b0, "init_to_setup");
      hold(20, 1'b1, 5'b0, "held_key");
      hold(3, 1'b0, 5'b0, "held_key_release");
      hold(1, 1'b0, F_EF, "end_fpga");
      press(F_M, "match_continue");
      press(F_M | F_EU, "round_advance");
      hold(1, 1'b0, F_EF, "end_fpga2");
      cycle(1'b1, F_ET | F_M, 1'b1, "timeout_press");
      hold(4, 1'b0, 5'b0, "timeout_hold");
      press(5'b0, "result_to_init");
      press(5'b0, "setup_start");
      hold(1, 1'b0, F_EF, "end_fpga3");
      press(5'b0, "mismatch");
      press(5'b0, "result_to_init2");
      press(5'b0, "setup_start2");
      hold(1, 1'b0, F_EF, "end_fpga4");
      press(F_M | F_W, "win");
      press(5'b0, "result_to_init3");
      press(5'b0, "setup_start3");
      hold(1, 1'b0, F_EF, "end_fpga5");
      async_reset(1'b1);
      hold(6, 1'b1, 5'b0, "held_through_reset");
      hold(2, 1'b0, 5'b0, "release_after_reset");
      press(5'b0, "press_after_reset");

      a = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3) == 0) a = ~a;
         f[4] = ($urandom_range(9) < 3);
         f[3] = ($urandom_range(9) < 3);
         f[2] = ($urandom_range(19) == 0);
         f[1] = ($urandom_range(9) == 0);
         f[0] = ($urandom_range(3) != 0);
         if ($urandom_range(199) == 0) async_reset(a);
         else cycle(a, f, 1'b1, "random");
      end

      @(posedge CLOCK_50); #2;
      if (q.size() != 0) begin
         n_chk++;
         $display("FAIL drain: pending=%0d expected pending=0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
